mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single memory port of the core between instruction fetch (IF) and the load/store unit (LS). It sits between `ifu`/`mmu` and the memory model, accepts one request at a time, and forwards it to memory over a valid/ready channel. It routes the memory response back to whichever requester issued it. LS has priority, and a starvation counter guarantees IF forward progress.

## Interface
- `DATA_WIDTH`, default 32: data bus width.
- `MEM_ADDR_WIDTH`, default 32: byte address width.
- `STARVE_LIMIT`, default 4: consecutive LS grants allowed while IF is waiting, before IF is forced through. Legal range 1..15.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `if_req_valid` in 1, `if_req_ready` out 1, `if_req_addr` in MEM_ADDR_WIDTH: fetch request channel.
- `if_resp_valid` out 1, `if_resp_data` out DATA_WIDTH: fetch response, one-cycle pulse.
- `ls_req_valid` in 1, `ls_req_ready` out 1, `ls_req_addr` in MEM_ADDR_WIDTH: load/store request channel.
- `ls_req_wen` in 1, `ls_req_wmask` in DATA_WIDTH/8, `ls_req_wdata` in DATA_WIDTH: write qualifiers for LS requests.
- `ls_resp_valid` out 1, `ls_resp_data` out DATA_WIDTH: LS response, one-cycle pulse. Data is 0 for writes.
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_req_addr` out MEM_ADDR_WIDTH: request channel to memory.
- `mem_req_wen` out 1, `mem_req_wmask` out DATA_WIDTH/8, `mem_req_wdata` out DATA_WIDTH: write qualifiers to memory.
- `mem_resp_valid` in 1, `mem_resp_data` in DATA_WIDTH: memory response. Exactly one response per accepted request, for reads and for writes.
- `busy` out 1: high whenever the arbiter is not in IDLE.

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - REQ: presenting the latched request to memory.
  - WAIT: awaiting the memory response.
- IDLE:
  - Grant rule: if `ls_req_valid` and (starve count < STARVE_LIMIT or `if_req_valid`=0), grant LS.
  - Otherwise, if `if_req_valid`, grant IF.
  - The granted requester sees `*_req_ready`=1 combinationally in that cycle. The other requester sees ready=0.
  - On grant, latch addr/wen/wmask/wdata and the owner, then go to REQ.
  - IF requests are latched with wen=0 and wmask=0.
- REQ:
  - `mem_req_valid`=1, driven only from the latched registers; never from combinational inputs.
  - On `mem_req_ready`=1, go to WAIT.
  - Fields stay stable while `mem_req_ready`=0.
- WAIT:
  - On `mem_resp_valid`, register the data into the owner's `*_resp_data` (0 if wen), pulse the owner's `*_resp_valid` the next cycle, and go to IDLE.
- Starve counter, 4 bits:
  - +1 on each LS grant made while `if_req_valid`=1.
  - Cleared on an IF grant, and on an LS grant made while `if_req_valid`=0.
  - Saturates at STARVE_LIMIT.
- `mem_resp_valid` seen outside WAIT is ignored. No state change occurs.
- Requester-side `*_req_ready` is 0 in REQ and WAIT. Requesters must hold valid and fields until ready.

## Timing
- Reset values:
  - state=IDLE, owner=IF, starve count=0.
  - All `*_valid`, `*_ready`, `busy`, and `mem_req_*` fields = 0.
  - Both `*_resp_data` = 0.
- Minimum latency, with memory ready in the same cycle and responding one cycle later:
  - Grant at cycle 0, `mem_req_valid` at cycle 1, `mem_resp_valid` at cycle 2, `*_resp_valid` at cycle 3.
- The `*_resp_valid` cycle is also an IDLE cycle. A new grant may occur in that same cycle, giving a back-to-back throughput of one transaction per 3 cycles minimum.
- Simultaneous IF and LS requests in IDLE follow the grant rule. The loser waits with ready=0 and must not be lost.
- Reset asserted mid-transaction: immediate return to IDLE, and the in-flight transaction is dropped. No response pulse is issued. The memory model is reset by the same `rst`.

## Structure
- Shared package `npc_bus_pkg`:
  - state enum {IDLE, REQ, WAIT}
  - owner enum {OWN_IF, OWN_LS}
  - default width constants.
- Sub-module `mem_arb_grant`: holds the combinational grant rule plus the starve counter register. Outputs are the grant and the owner.
- The top-level FSM, request latches and response registers live in `mem_bus_arbiter`.

## Test plan
- Single IF read: addr 0x80000000, memory returns 0x00000413 after 1 cycle. Required: `if_resp_valid` pulses once at cycle 3 with that data; `ls_resp_valid` stays 0.
- LS write: addr 0x80001000, wmask 0xF, wdata 0xDEADBEEF. Required: memory sees wen=1 with the exact fields; `ls_resp_valid` pulses with data 0.
- IF and LS valid in the same IDLE cycle. Required: `ls_req_ready`=1 and `if_req_ready`=0; IF is granted on the next IDLE.
- LS and IF both held valid continuously, STARVE_LIMIT=4. Required: grant sequence LS,LS,LS,LS,IF,LS...
- `mem_req_ready` held 0 for 5 cycles. Required: `mem_req_*` fields stay stable; `busy`=1 throughout.
- `rst` dropped to 0 during WAIT, then released. Required: all outputs return to 0 asynchronously; no response pulse; the next IF request completes normally.

Source files
------------

// File: rtl/npc_bus_pkg.sv
// Shared types and default widths for the core's memory-port arbiter.
package npc_bus_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_MEM_ADDR_WIDTH = 32;
  localparam int DEF_STARVE_LIMIT   = 4;
  localparam int STARVE_CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester (IF, LS) and memory channels around the arbiter.
// slave: the arbiter itself; master: the core requesters plus the memory model.
interface mem_bus_arbiter_if
  import npc_bus_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
);
  logic                      if_req_valid;
  logic                      if_req_ready;
  logic [MEM_ADDR_WIDTH-1:0] if_req_addr;
  logic                      if_resp_valid;
  logic [DATA_WIDTH-1:0]     if_resp_data;

  logic                      ls_req_valid;
  logic                      ls_req_ready;
  logic [MEM_ADDR_WIDTH-1:0] ls_req_addr;
  logic                      ls_req_wen;
  logic [DATA_WIDTH/8-1:0]   ls_req_wmask;
  logic [DATA_WIDTH-1:0]     ls_req_wdata;
  logic                      ls_resp_valid;
  logic [DATA_WIDTH-1:0]     ls_resp_data;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [MEM_ADDR_WIDTH-1:0] mem_req_addr;
  logic                      mem_req_wen;
  logic [DATA_WIDTH/8-1:0]   mem_req_wmask;
  logic [DATA_WIDTH-1:0]     mem_req_wdata;
  logic                      mem_resp_valid;
  logic [DATA_WIDTH-1:0]     mem_resp_data;

  logic                      busy;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_data,
    input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wmask, ls_req_wdata,
    output ls_req_ready, ls_resp_valid, ls_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output busy
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_data,
    output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wmask, ls_req_wdata,
    input  ls_req_ready, ls_resp_valid, ls_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  busy
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Grant decision between IF and LS with a saturating starvation counter that
// forces IF through after STARVE_LIMIT consecutive LS grants while IF waits.
module mem_arb_grant
  import npc_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idle,
  input  logic       if_valid,
  input  logic       ls_valid,
  output logic       grant,
  output arb_owner_e owner
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    grant_ls;
  logic                    grant_if;

  // No grant is offered while reset is held, so both readies read 0.
  always_comb begin
    grant_ls = rst && idle && ls_valid && ((starve_cnt < LIMIT) || !if_valid);
    grant_if = rst && idle && if_valid && !grant_ls;
  end

  assign grant = grant_ls || grant_if;
  assign owner = grant_ls ? OWN_LS : OWN_IF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_ls) begin
      if (!if_valid)
        starve_cnt <= '0;
      else if (starve_cnt < LIMIT)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the core's single memory port between instruction fetch and the
// load/store unit; one transaction in flight, response routed to its owner.
module mem_bus_arbiter
  import npc_bus_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.slave  bus
);

  localparam int MASK_W = DATA_WIDTH / 8;

  arb_state_e                state;
  arb_state_e                state_nxt;
  arb_owner_e                owner_q;
  arb_owner_e                grant_owner;
  logic                      grant;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic                      wen_q;
  logic [MASK_W-1:0]         wmask_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      if_resp_valid_q;
  logic                      ls_resp_valid_q;
  logic [DATA_WIDTH-1:0]     if_resp_data_q;
  logic [DATA_WIDTH-1:0]     ls_resp_data_q;

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk      (clk),
    .rst      (rst),
    .idle     (state == IDLE),
    .if_valid (bus.if_req_valid),
    .ls_valid (bus.ls_req_valid),
    .grant    (grant),
    .owner    (grant_owner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant)              state_nxt = REQ;
      REQ:     if (bus.mem_req_ready)  state_nxt = WAIT;
      WAIT:    if (bus.mem_resp_valid) state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Memory sees only registered fields; they are zeroed outside REQ.
  always_comb begin
    bus.if_req_ready  = grant && (grant_owner == OWN_IF);
    bus.ls_req_ready  = grant && (grant_owner == OWN_LS);
    bus.mem_req_valid = (state == REQ);
    bus.mem_req_addr  = (state == REQ) ? addr_q  : '0;
    bus.mem_req_wen   = (state == REQ) ? wen_q   : 1'b0;
    bus.mem_req_wmask = (state == REQ) ? wmask_q : '0;
    bus.mem_req_wdata = (state == REQ) ? wdata_q : '0;
    bus.busy          = (state != IDLE);
    bus.if_resp_valid = if_resp_valid_q;
    bus.if_resp_data  = if_resp_data_q;
    bus.ls_resp_valid = ls_resp_valid_q;
    bus.ls_resp_data  = ls_resp_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_IF;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner_q <= grant_owner;
      if (grant_owner == OWN_LS) begin
        addr_q  <= bus.ls_req_addr;
        wen_q   <= bus.ls_req_wen;
        wmask_q <= bus.ls_req_wmask;
        wdata_q <= bus.ls_req_wdata;
      end else begin
        addr_q  <= bus.if_req_addr;
        wen_q   <= 1'b0;
        wmask_q <= '0;
        wdata_q <= '0;
      end
    end
  end

  // Response data is held between pulses; writes return 0 to LS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_resp_valid_q <= 1'b0;
      ls_resp_valid_q <= 1'b0;
      if_resp_data_q  <= '0;
      ls_resp_data_q  <= '0;
    end else begin
      if_resp_valid_q <= 1'b0;
      ls_resp_valid_q <= 1'b0;
      if ((state == WAIT) && bus.mem_resp_valid) begin
        if (owner_q == OWN_LS) begin
          ls_resp_valid_q <= 1'b1;
          ls_resp_data_q  <= wen_q ? '0 : bus.mem_resp_data;
        end else begin
          if_resp_valid_q <= 1'b1;
          if_resp_data_q  <= bus.mem_resp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: queue-driven IF/LS requesters, a one-cycle memory,
// a transaction-level reference model checked every cycle, plus directed cases.
module tb_mem_bus_arbiter;
  import npc_bus_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int LIMIT = 4;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic spur = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) bus ();

  mem_bus_arbiter #(
    .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return a ^ 32'h80000413;
  endfunction

  req_t if_q[$];
  req_t ls_q[$];
  int   if_idx = 0;
  int   ls_idx = 0;

  // Requesters hold each queued request until accepted; memory answers one cycle after accept.
  initial begin : agent
    bit          if_fire, ls_fire, acc;
    logic [31:0] acc_addr;
    bus.if_req_valid   = 1'b0;
    bus.if_req_addr    = '0;
    bus.ls_req_valid   = 1'b0;
    bus.ls_req_addr    = '0;
    bus.ls_req_wen     = 1'b0;
    bus.ls_req_wmask   = '0;
    bus.ls_req_wdata   = '0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if_fire  = bus.if_req_valid && bus.if_req_ready;
      ls_fire  = bus.ls_req_valid && bus.ls_req_ready;
      acc      = bus.mem_req_valid && bus.mem_req_ready;
      acc_addr = bus.mem_req_addr;
      @(posedge clk);
      #1;
      if (!rst) begin
        if_idx = if_q.size();
        ls_idx = ls_q.size();
        acc    = 1'b0;
      end else begin
        if (if_fire) if_idx++;
        if (ls_fire) ls_idx++;
      end
      bus.if_req_valid = rst && (if_idx < if_q.size());
      if (if_idx < if_q.size()) bus.if_req_addr = if_q[if_idx].addr;
      bus.ls_req_valid = rst && (ls_idx < ls_q.size());
      if (ls_idx < ls_q.size()) begin
        bus.ls_req_addr  = ls_q[ls_idx].addr;
        bus.ls_req_wen   = ls_q[ls_idx].wen;
        bus.ls_req_wmask = ls_q[ls_idx].wmask;
        bus.ls_req_wdata = ls_q[ls_idx].wdata;
      end
      bus.mem_resp_valid = rst && (acc || spur);
      bus.mem_resp_data  = spur ? 32'hBAD0BAD0 : (acc ? rd_data(acc_addr) : 32'h0);
    end
  end

  // Reference model: one outstanding transaction, its fields, and the starvation tally.
  bit          m_out, m_acc, m_pulse, m_pls, m_tls, ls_g, if_g, mv;
  int          m_starve;
  req_t        m_t;
  logic [31:0] m_if_data, m_ls_data;

  int          cyc = 0;
  int          grant_log[$];
  int          if_pulses = 0, ls_pulses = 0, if_grant_cyc = 0, if_resp_cyc = 0;
  logic [31:0] seen_if_data = '0, seen_ls_data = '0;
  req_t        seen_acc;
  logic [1:0]  conflict_rdy = 2'b00;

  initial begin : monitor
    m_out = 0; m_acc = 0; m_pulse = 0; m_pls = 0; m_tls = 0; m_starve = 0;
    m_if_data = '0; m_ls_data = '0;
    m_t = '{32'h0, 1'b0, 4'h0, 32'h0};
    seen_acc = '{32'h0, 1'b0, 4'h0, 32'h0};
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        chk("rst_if_req_ready",  64'(bus.if_req_ready),  64'(0));
        chk("rst_ls_req_ready",  64'(bus.ls_req_ready),  64'(0));
        chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
        chk("rst_mem_req_addr",  64'(bus.mem_req_addr),  64'(0));
        chk("rst_busy",          64'(bus.busy),          64'(0));
        chk("rst_if_resp_valid", 64'(bus.if_resp_valid), 64'(0));
        chk("rst_ls_resp_valid", 64'(bus.ls_resp_valid), 64'(0));
        chk("rst_if_resp_data",  64'(bus.if_resp_data),  64'(0));
        chk("rst_ls_resp_data",  64'(bus.ls_resp_data),  64'(0));
        m_out = 0; m_acc = 0; m_pulse = 0; m_pls = 0; m_starve = 0;
        m_if_data = '0; m_ls_data = '0;
      end else begin
        ls_g = !m_out && bus.ls_req_valid && ((m_starve < LIMIT) || !bus.if_req_valid);
        if_g = !m_out && bus.if_req_valid && !ls_g;
        mv   = m_out && !m_acc;
        chk("ls_req_ready",  64'(bus.ls_req_ready),  64'(ls_g));
        chk("if_req_ready",  64'(bus.if_req_ready),  64'(if_g));
        chk("busy",          64'(bus.busy),          64'(m_out));
        chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(mv));
        chk("mem_req_addr",  64'(bus.mem_req_addr),  64'(mv ? m_t.addr  : 32'h0));
        chk("mem_req_wen",   64'(bus.mem_req_wen),   64'(mv ? m_t.wen   : 1'b0));
        chk("mem_req_wmask", 64'(bus.mem_req_wmask), 64'(mv ? m_t.wmask : 4'h0));
        chk("mem_req_wdata", 64'(bus.mem_req_wdata), 64'(mv ? m_t.wdata : 32'h0));
        chk("if_resp_valid", 64'(bus.if_resp_valid), 64'(m_pulse && !m_pls));
        chk("ls_resp_valid", 64'(bus.ls_resp_valid), 64'(m_pulse && m_pls));
        chk("if_resp_data",  64'(bus.if_resp_data),  64'(m_if_data));
        chk("ls_resp_data",  64'(bus.ls_resp_data),  64'(m_ls_data));

        if (bus.if_resp_valid) begin if_pulses++; if_resp_cyc = cyc; seen_if_data = bus.if_resp_data; end
        if (bus.ls_resp_valid) begin ls_pulses++; seen_ls_data = bus.ls_resp_data; end
        if (bus.if_req_ready) begin grant_log.push_back(0); if_grant_cyc = cyc; end
        if (bus.ls_req_ready) grant_log.push_back(1);
        if (bus.if_req_valid && bus.ls_req_valid && (bus.if_req_ready || bus.ls_req_ready))
          conflict_rdy = {bus.ls_req_ready, bus.if_req_ready};
        if (bus.mem_req_valid && bus.mem_req_ready)
          seen_acc = '{bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wmask, bus.mem_req_wdata};

        m_pulse = 0;
        if (m_out) begin
          if (m_acc) begin
            if (bus.mem_resp_valid) begin
              m_out = 0; m_pulse = 1; m_pls = m_tls;
              if (m_tls) m_ls_data = m_t.wen ? 32'h0 : bus.mem_resp_data;
              else       m_if_data = bus.mem_resp_data;
            end
          end else if (bus.mem_req_ready) begin
            m_acc = 1;
          end
        end else if (ls_g || if_g) begin
          m_out = 1; m_acc = 0; m_tls = ls_g;
          if (ls_g) begin
            m_t = '{bus.ls_req_addr, bus.ls_req_wen, bus.ls_req_wmask, bus.ls_req_wdata};
            if (!bus.if_req_valid)    m_starve = 0;
            else if (m_starve < LIMIT) m_starve = m_starve + 1;
          end else begin
            m_t = '{bus.if_req_addr, 1'b0, 4'h0, 32'h0};
            m_starve = 0;
          end
        end
      end
    end
  end

  function automatic int glog(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((if_idx >= if_q.size()) && (ls_idx >= ls_q.size()) && !bus.busy &&
                 !bus.if_req_valid && !bus.ls_req_valid &&
                 !bus.if_resp_valid && !bus.ls_resp_valid) && (n < 300));
    chk({name, "_timeout"}, 64'(n >= 300), 64'(0));
  endtask

  initial begin : stim
    int b_if, b_ls, base, n;
    int exp_seq[8];
    exp_seq = '{1, 1, 1, 1, 0, 1, 1, 0};
    bus.mem_req_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",          64'(bus.busy),          64'(0));
    chk("reset_mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
    chk("reset_mem_req_wen",   64'(bus.mem_req_wen),   64'(0));
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.mem_req_ready = 1'b1;

    // Single IF read
    b_if = if_pulses; b_ls = ls_pulses;
    if_q.push_back('{32'h80000000, 1'b0, 4'h0, 32'h0});
    drain("if_read");
    chk("if_read_pulses",  64'(if_pulses - b_if), 64'(1));
    chk("if_read_ls_quiet", 64'(ls_pulses - b_ls), 64'(0));
    chk("if_read_latency", 64'(if_resp_cyc - if_grant_cyc), 64'(3));
    chk("if_read_data",    64'(seen_if_data), 64'(32'h00000413));

    // LS write
    b_ls = ls_pulses;
    ls_q.push_back('{32'h80001000, 1'b1, 4'hF, 32'hDEADBEEF});
    drain("ls_write");
    chk("ls_write_addr",   64'(seen_acc.addr),  64'(32'h80001000));
    chk("ls_write_wen",    64'(seen_acc.wen),   64'(1));
    chk("ls_write_wmask",  64'(seen_acc.wmask), 64'(4'hF));
    chk("ls_write_wdata",  64'(seen_acc.wdata), 64'(32'hDEADBEEF));
    chk("ls_write_pulses", 64'(ls_pulses - b_ls), 64'(1));
    chk("ls_write_data",   64'(seen_ls_data), 64'(0));

    // Simultaneous IF and LS
    base = grant_log.size();
    if_q.push_back('{32'h80000010, 1'b0, 4'h0, 32'h0});
    ls_q.push_back('{32'h80000020, 1'b0, 4'h0, 32'h0});
    drain("conflict");
    chk("conflict_ready", 64'(conflict_rdy), 64'(2'b10));
    chk("conflict_first", 64'(glog(base)),     64'(1));
    chk("conflict_second", 64'(glog(base + 1)), 64'(0));
    chk("conflict_if_data", 64'(seen_if_data), 64'(32'h00000403));
    chk("conflict_ls_data", 64'(seen_ls_data), 64'(32'h00000433));

    // Starvation: both held valid
    base = grant_log.size();
    b_if = if_pulses; b_ls = ls_pulses;
    for (int i = 0; i < 6; i++) ls_q.push_back('{32'h80000100 + 32'(4 * i), 1'b0, 4'h0, 32'h0});
    if_q.push_back('{32'h80000200, 1'b0, 4'h0, 32'h0});
    if_q.push_back('{32'h80000204, 1'b0, 4'h0, 32'h0});
    drain("starve");
    for (int i = 0; i < 8; i++) chk($sformatf("starve_grant_%0d", i), 64'(glog(base + i)), 64'(exp_seq[i]));
    chk("starve_if_pulses", 64'(if_pulses - b_if), 64'(2));
    chk("starve_ls_pulses", 64'(ls_pulses - b_ls), 64'(6));

    // Memory stall with a stray response during REQ
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b0;
    b_ls = ls_pulses;
    ls_q.push_back('{32'h80002000, 1'b0, 4'h0, 32'h0});
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_req_valid && n < 20);
    chk("stall_req_seen", 64'(n >= 20), 64'(0));
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 64'(bus.mem_req_valid), 64'(1));
      chk("stall_addr",  64'(bus.mem_req_addr),  64'(32'h80002000));
      chk("stall_wen",   64'(bus.mem_req_wen),   64'(0));
      chk("stall_busy",  64'(bus.busy),          64'(1));
      @(posedge clk);
      #1;
      spur = (k == 1);
      if (k == 4) bus.mem_req_ready = 1'b1;
      @(negedge clk);
    end
    spur = 1'b0;
    drain("stall");
    chk("stall_pulses", 64'(ls_pulses - b_ls), 64'(1));
    chk("stall_data",   64'(seen_ls_data), 64'(32'h00002413));

    // Reset during WAIT
    @(posedge clk);
    #1;
    if_q.push_back('{32'h80003000, 1'b0, 4'h0, 32'h0});
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.mem_req_valid && bus.mem_req_ready) && n < 20);
    chk("rstwait_accept_seen", 64'(n >= 20), 64'(0));
    @(posedge clk);
    #3;
    chk("rstwait_busy_before", 64'(bus.busy), 64'(1));
    b_if = if_pulses; b_ls = ls_pulses;
    rst = 1'b0;
    #1;
    chk("rstwait_busy",          64'(bus.busy),          64'(0));
    chk("rstwait_mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
    chk("rstwait_if_resp_valid", 64'(bus.if_resp_valid), 64'(0));
    chk("rstwait_if_resp_data",  64'(bus.if_resp_data),  64'(0));
    chk("rstwait_ls_resp_data",  64'(bus.ls_resp_data),  64'(0));
    chk("rstwait_if_req_ready",  64'(bus.if_req_ready),  64'(0));
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstwait_no_if_pulse", 64'(if_pulses - b_if), 64'(0));
    chk("rstwait_no_ls_pulse", 64'(ls_pulses - b_ls), 64'(0));
    b_if = if_pulses;
    if_q.push_back('{32'h80004000, 1'b0, 4'h0, 32'h0});
    drain("after_reset");
    chk("after_reset_pulses",  64'(if_pulses - b_if), 64'(1));
    chk("after_reset_data",    64'(seen_if_data), 64'(32'h00004413));
    chk("after_reset_latency", 64'(if_resp_cyc - if_grant_cyc), 64'(3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
